// File: rtl/touch_key_debounce.sv
// Debounces the three touch-zone hit flags into press / auto-repeat / release
// events with a held level and a latched 2-bit key code.
module touch_key_debounce #(
    parameter int DEB_CNT  = 4,
    parameter int HOLD_CNT = 50,
    parameter int REP_CNT  = 10,
    parameter int REL_CNT  = 4,
    parameter int CW       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       t_twfi,
    input  logic       t_fiei,
    input  logic       t_eion,
    output logic [1:0] key_code,
    output logic       key_held,
    output logic       key_press,
    output logic       key_repeat,
    output logic       key_release
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_PRESSED,
        S_REPEAT,
        S_RELEASE
    } state_e;

    localparam logic [CW-1:0] DEB_T  = CW'(DEB_CNT);
    localparam logic [CW-1:0] HOLD_T = CW'(HOLD_CNT);
    localparam logic [CW-1:0] REP_T  = CW'(REP_CNT);
    localparam logic [CW-1:0] REL_T  = CW'(REL_CNT);
    localparam logic [CW-1:0] ONE    = CW'(1);

    state_e        state_q, state_d;
    logic [1:0]    cand_q, cand_d;
    logic [1:0]    code_q, code_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic          held_q, held_d;
    logic          press_q, press_d;
    logic          rep_q, rep_d;
    logic          rel_q, rel_d;

    logic [1:0]    sample_code;
    logic [CW-1:0] cnt_inc, rcnt_inc;

    // Zero or multiple simultaneous hits both decode as "no key".
    always_comb begin
        case ({t_twfi, t_fiei, t_eion})
            3'b100:  sample_code = 2'd1;
            3'b010:  sample_code = 2'd2;
            3'b001:  sample_code = 2'd3;
            default: sample_code = 2'd0;
        endcase
    end

    assign cnt_inc  = cnt_q + ONE;
    assign rcnt_inc = rcnt_q + ONE;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves a latch.
        state_d = state_q;
        cand_d  = cand_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        held_d  = held_q;
        press_d = 1'b0;
        rep_d   = 1'b0;
        rel_d   = 1'b0;

        if (enable) begin
            case (state_q)
                S_IDLE: begin
                    if (sample_code != 2'd0) begin
                        cand_d  = sample_code;
                        cnt_d   = ONE;
                        state_d = S_DEBOUNCE;
                    end
                end
                S_DEBOUNCE: begin
                    if (sample_code == cand_q) begin
                        if (cnt_inc == DEB_T) begin
                            state_d = S_PRESSED;
                            code_d  = cand_q;
                            held_d  = 1'b1;
                            press_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else if (sample_code != 2'd0) begin
                        cand_d = sample_code;
                        cnt_d  = ONE;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
                S_PRESSED, S_REPEAT: begin
                    if (sample_code == code_q) begin
                        if (cnt_inc == ((state_q == S_PRESSED) ? HOLD_T : REP_T)) begin
                            rep_d   = 1'b1;
                            cnt_d   = '0;
                            state_d = S_REPEAT;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = S_RELEASE;
                        rcnt_d  = ONE;
                        cnt_d   = '0;
                    end
                end
                S_RELEASE: begin
                    if (sample_code == code_q) begin
                        // Key came back before the release filter expired: hold timing restarts.
                        state_d = S_PRESSED;
                        cnt_d   = '0;
                        rcnt_d  = '0;
                    end else if (rcnt_inc == REL_T) begin
                        state_d = S_IDLE;
                        rel_d   = 1'b1;
                        held_d  = 1'b0;
                        code_d  = 2'd0;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_inc;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cand_q  <= 2'd0;
            code_q  <= 2'd0;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            held_q  <= 1'b0;
            press_q <= 1'b0;
            rep_q   <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            held_q  <= held_d;
            press_q <= press_d;
            rep_q   <= rep_d;
            rel_q   <= rel_d;
        end
    end

    assign key_code    = code_q;
    assign key_held    = held_q;
    assign key_press   = press_q;
    assign key_repeat  = rep_q;
    assign key_release = rel_q;

endmodule

// File: tb/tb_touch_key_debounce.sv
// Bench for touch_key_debounce: directed scenarios plus randomized key traffic,
// all compared every cycle against a run-length based behavioural model.
module tb_touch_key_debounce;

    localparam int DEB  = 4;
    localparam int HOLD = 50;
    localparam int REP  = 10;
    localparam int REL  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       t_twfi = 1'b0, t_fiei = 1'b0, t_eion = 1'b0;
    logic [1:0] key_code;
    logic       key_held, key_press, key_repeat, key_release;

    int checks = 0;
    int passed = 0;

    touch_key_debounce #(
        .DEB_CNT(DEB), .HOLD_CNT(HOLD), .REP_CNT(REP), .REL_CNT(REL), .CW(8)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .t_twfi(t_twfi), .t_fiei(t_fiei), .t_eion(t_eion),
        .key_code(key_code), .key_held(key_held), .key_press(key_press),
        .key_repeat(key_repeat), .key_release(key_release)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    function automatic int decode(input logic [2:0] f);
        case (f)
            3'b100:  return 1;
            3'b010:  return 2;
            3'b001:  return 3;
            default: return 0;
        endcase
    endfunction

    // Behavioural model: run lengths of matching / non-matching samples and
    // modular arithmetic on the hold age decide each event.
    int   m_key, m_cand, m_streak, m_age, m_gap;
    logic exp_press, exp_rep, exp_rel;

    always @(posedge clk or negedge reset) begin
        int c;
        if (!reset) begin
            m_key = 0; m_cand = 0; m_streak = 0; m_age = 0; m_gap = 0;
            exp_press = 0; exp_rep = 0; exp_rel = 0;
        end else begin
            exp_press = 0; exp_rep = 0; exp_rel = 0;
            if (enable) begin
                c = decode({t_twfi, t_fiei, t_eion});
                if (m_key == 0) begin
                    if (c == 0) m_streak = 0;
                    else if (c == m_cand && m_streak > 0) m_streak++;
                    else begin m_cand = c; m_streak = 1; end
                    if (m_streak == DEB) begin
                        m_key = m_cand; m_age = 0; m_gap = 0; m_streak = 0;
                        exp_press = 1;
                    end
                end else if (c == m_key) begin
                    if (m_gap > 0) begin
                        m_gap = 0; m_age = 0;
                    end else begin
                        m_age++;
                        if (m_age == HOLD || (m_age > HOLD && (m_age - HOLD) % REP == 0))
                            exp_rep = 1;
                    end
                end else begin
                    m_gap++;
                    if (m_gap == REL) begin
                        m_key = 0; m_cand = 0; m_streak = 0; m_gap = 0;
                        exp_rel = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("outputs {code,held,press,rep,rel}",
              {27'd0, key_code, key_held, key_press, key_repeat, key_release},
              {27'd0, 2'(m_key), (m_key != 0), exp_press, exp_rep, exp_rel});
    end

    // Event monitor used by the directed literal expectations.
    int sample_idx, n_press, n_rep, n_rel, press_idx, rel_idx;
    int rep_idx[8];

    always @(negedge clk) begin
        if (key_press) begin n_press++; press_idx = sample_idx; end
        if (key_repeat) begin
            if (n_rep < 8) rep_idx[n_rep] = sample_idx;
            n_rep++;
        end
        if (key_release) begin n_rel++; rel_idx = sample_idx; end
    end

    task automatic clear_stats();
        sample_idx = 0; n_press = 0; n_rep = 0; n_rel = 0; press_idx = 0; rel_idx = 0;
        for (int i = 0; i < 8; i++) rep_idx[i] = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0; enable = 1'b0;
        {t_twfi, t_fiei, t_eion} = 3'b000;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        clear_stats();
    endtask

    // Called at a negedge: one enable clock, then gap idle clocks.
    task automatic smp(input logic [2:0] f, input int gap);
        {t_twfi, t_fiei, t_eion} = f;
        enable = 1'b1;
        sample_idx++;
        @(negedge clk);
        enable = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        logic [2:0] seg_f, f;
        int run;

        clear_stats();
        do_reset();
        check("reset outputs", {27'd0, key_code, key_held, key_press, key_repeat, key_release}, 32'd0);

        // Press: fiei for 4 samples, enable every 4th clock.
        for (int i = 0; i < 3; i++) smp(3'b010, 3);
        check("press none after 3", n_press, 0);
        smp(3'b010, 3);
        check("press count", n_press, 1);
        check("press sample", press_idx, 4);
        check("press code", key_code, 2);
        check("press held", key_held, 1);

        // Bounce: a zero sample restarts the debounce.
        do_reset();
        for (int i = 0; i < 3; i++) smp(3'b100, 3);
        smp(3'b000, 3);
        for (int i = 0; i < 4; i++) smp(3'b100, 3);
        check("bounce press count", n_press, 1);
        check("bounce press sample", press_idx, 8);
        check("bounce code", key_code, 1);

        // Auto-repeat over 80 held samples.
        do_reset();
        for (int i = 0; i < 80; i++) smp(3'b001, 1);
        check("repeat press sample", press_idx, 4);
        check("repeat count", n_rep, 3);
        check("repeat 1 sample", rep_idx[0], 54);
        check("repeat 2 sample", rep_idx[1], 64);
        check("repeat 3 sample", rep_idx[2], 74);
        check("repeat no release", n_rel, 0);

        // Release filter.
        do_reset();
        for (int i = 0; i < 4; i++) smp(3'b010, 3);
        for (int i = 0; i < 3; i++) smp(3'b000, 3);
        smp(3'b010, 3);
        check("filter no release", n_rel, 0);
        check("filter held", key_held, 1);
        for (int i = 0; i < 4; i++) smp(3'b000, 3);
        check("release count", n_rel, 1);
        check("release sample", rel_idx, 12);
        check("release held", key_held, 0);
        check("release code", key_code, 0);

        // Invalid two-flag input never presses.
        do_reset();
        for (int i = 0; i < 10; i++) smp(3'b101, 3);
        check("invalid events", n_press + n_rep + n_rel, 0);
        check("invalid held", key_held, 0);

        // Freeze mid-debounce: inputs ignored while enable is low.
        do_reset();
        for (int i = 0; i < 2; i++) smp(3'b100, 3);
        {t_twfi, t_fiei, t_eion} = 3'b001;
        repeat (20) @(negedge clk);
        check("freeze no press", n_press, 0);
        for (int i = 0; i < 2; i++) smp(3'b100, 3);
        check("freeze press count", n_press, 1);
        check("freeze press sample", press_idx, 4);

        // Asynchronous reset while repeating.
        do_reset();
        for (int i = 0; i < 60; i++) smp(3'b001, 0);
        check("areset in repeat", n_rep, 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check("areset outputs", {27'd0, key_code, key_held, key_press, key_repeat, key_release}, 32'd0);
        repeat (3) @(negedge clk);
        check("areset no release", n_rel, 0);
        reset = 1'b1;
        @(negedge clk);
        clear_stats();
        for (int i = 0; i < 3; i++) smp(3'b001, 3);
        check("areset fresh none", n_press, 0);
        smp(3'b001, 3);
        check("areset fresh press", n_press, 1);
        check("areset fresh sample", press_idx, 4);

        // Randomized traffic: runs of a key pattern with occasional glitches.
        do_reset();
        for (int s = 0; s < 40; s++) begin
            case ($urandom_range(0, 5))
                0: seg_f = 3'b100;
                1: seg_f = 3'b010;
                2: seg_f = 3'b001;
                3: seg_f = 3'b000;
                4: seg_f = 3'b011;
                default: seg_f = 3'b111;
            endcase
            run = $urandom_range(1, 70);
            for (int i = 0; i < run; i++) begin
                f = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : seg_f;
                smp(f, $urandom_range(0, 3));
            end
        end
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
